alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one 16-bit ALU between two requesters: port 0 is the datapath issue stage and port 1 is the debug/address-generation unit.
- Uses round-robin arbitration with a valid/ready handshake on each request port.
- Supports an optional lock, so one requester can issue back-to-back operations without interleaving.
- Result, zero flag and requester ID are captured in a one-entry output register with its own valid/ready handshake.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU datapath.
- OPW, 4, ALU control width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand A.
- req0_b  in  WIDTH  operand B.
- req0_op  in  OPW  ALU control.
- req0_lock  in  1  keep the grant after this operation.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_lock: same as requester 0, for requester 1.
- rsp_valid  out  1  result register holds a result.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  WIDTH  ALU result.
- rsp_zero  out  1  result == 0.
- rsp_id  out  1  requester that issued the result.
- locked  out  1  arbiter is in the LOCKED state.

Behaviour:
- Reset (async, active-high) values:
  - rsp_valid=0, rsp_result=0, rsp_zero=0, rsp_id=0, locked=0.
  - State=ARB, lock owner=0, last_grant=1, so requester 0 wins the first tie.
  - req*_ready=0 while reset is asserted.
- Slot free: slot_free = !rsp_valid || rsp_ready. No grant is issued unless slot_free.
- ARB state grant rules:
  - Only one valid requester: it is granted.
  - Both valid: grant goes to the requester != last_grant.
- LOCKED state grant rules:
  - Only the lock owner can be granted.
  - The other requester sees ready=0 even if the owner is idle.
- reqN_ready is combinational: slot_free && grantN && !reset. At most one ready is high per cycle.
- Acceptance: valid && ready at a rising edge. Only then:
  - last_grant is set to N.
  - The result register loads the ALU output for the granted operands: rsp_result, rsp_zero, rsp_id=N, rsp_valid=1.
- Latency: result is visible the cycle after acceptance (1 cycle).
- Back-to-back: a new operation is accepted in the same cycle the previous result is drained (rsp_ready=1), giving full throughput of 1 op/cycle.
- Result register hold/clear:
  - rsp_valid && !rsp_ready: the register holds and all reqN_ready=0.
  - rsp_ready && no acceptance: rsp_valid goes to 0 and data is held.
- ALU operation encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
  - SLT is an unsigned compare, result 1/0.
  - Any other code is treated as ADD.
  - ADD/SUB wrap modulo 2^WIDTH; there is no carry or overflow output.
- State machine:
  - ARB -> LOCKED: on acceptance with reqN_lock=1; the owner becomes N.
  - LOCKED -> ARB: on acceptance from the owner with lock=0; that operation still completes normally.
  - LOCKED persists while the owner is idle (no timeout).
- Locked output: locked=1 exactly when state=LOCKED.
- Operand/op stability: operands and op are sampled only at acceptance. Requesters may change them freely while ready=0.
- Reset mid-operation: any held result is discarded (rsp_valid=0) and LOCKED is abandoned (state=ARB).

Decomposition:
- Shared package (alu_pkg):
  - ALU op constants: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT.
  - WIDTH default.
  - State encoding: ST_ARB, ST_LOCKED.
- Sub-module: instantiate the existing combinational alu module (inputs a, b, alu_cntrl; outputs result, zero) behind a 2:1 operand/op mux driven by the grant.
- Arbitration and the output register stay in alu_arbiter.

Test Plan:
- Single request: req0 a=0x0005, b=0x0003, op=0010 with rsp_ready=1 -> next cycle rsp_valid=1, result=0x0008, zero=0, id=0.
- Tie and round-robin: both valid every cycle with rsp_ready=1 -> grants alternate 0,1,0,1 starting with 0; req1 SUB 0x0004-0x0004 gives result=0, zero=1, id=1.
- Backpressure: rsp_ready=0 after the first result -> both ready=0 and the result holds for 5 cycles; rsp_ready=1 drains it and accepts the next op in the same cycle.
- Lock: req1 issues 3 ops with lock=1,1,0 while req0 is continuously valid -> req0 is not granted until after the third req1 op; locked=1 for exactly 2 cycles following acceptances; the next grant goes to req0.
- Arithmetic edges: ADD 0xFFFF+0x0001 -> 0x0000, zero=1; SLT 0x0001<0xFFFF -> 0x0001; SLT 0xFFFF<0x0001 -> 0x0000; op=1111 with 2+3 -> 0x0005.
- Async reset while locked with rsp_valid=1 -> rsp_valid, locked and rsp_result go to 0 immediately without waiting for a clock; after release, a tie grants req0 first.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter:
// default widths, ALU control encodings and arbiter state encoding.
package alu_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_OPW   = 4;

  localparam logic [DEFAULT_OPW-1:0] ALU_AND = 4'b0000;
  localparam logic [DEFAULT_OPW-1:0] ALU_OR  = 4'b0001;
  localparam logic [DEFAULT_OPW-1:0] ALU_ADD = 4'b0010;
  localparam logic [DEFAULT_OPW-1:0] ALU_SUB = 4'b0110;
  localparam logic [DEFAULT_OPW-1:0] ALU_SLT = 4'b0111;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: AND, OR, ADD, SUB, unsigned SLT; unknown codes add.
// Arithmetic wraps modulo 2^WIDTH with no carry/overflow output.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   alu_cntrl,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  always_comb begin
    result = a + b;
    case (alu_cntrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, (a < b)};
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters,
// with an optional grant lock and a one-entry result register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int OPW   = DEFAULT_OPW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req0_lock,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  input  logic             req1_lock,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_id,
  output logic             locked
);

  state_t           state, state_next;
  logic             owner, owner_next;
  logic             last_grant;
  logic             slot_free;
  logic             grant0, grant1;
  logic             acc0, acc1, accept, acc_lock;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [OPW-1:0]   alu_op;
  logic             alu_zero;

  assign slot_free = !rsp_valid || rsp_ready;

  // In LOCKED only the owner may win; in ARB a tie goes away from last_grant.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_LOCKED) begin
      grant0 = req0_valid && !owner;
      grant1 = req1_valid && owner;
    end else begin
      grant0 = req0_valid && (!req1_valid || last_grant);
      grant1 = req1_valid && (!req0_valid || !last_grant);
    end
  end

  assign req0_ready = slot_free && grant0 && !reset;
  assign req1_ready = slot_free && grant1 && !reset;
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign accept     = acc0 || acc1;
  assign acc_lock   = acc1 ? req1_lock : req0_lock;

  assign alu_a  = grant1 ? req1_a  : req0_a;
  assign alu_b  = grant1 ? req1_b  : req0_b;
  assign alu_op = grant1 ? req1_op : req0_op;

  alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .alu_cntrl (alu_op),
    .result    (alu_result),
    .zero      (alu_zero)
  );

  always_comb begin
    state_next = state;
    owner_next = owner;
    case (state)
      ST_ARB: begin
        if (accept && acc_lock) begin
          state_next = ST_LOCKED;
          owner_next = acc1;
        end
      end
      ST_LOCKED: begin
        if (accept && !acc_lock) state_next = ST_ARB;
      end
      default: state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_ARB;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      owner <= owner_next;
      if (accept) last_grant <= acc1;
    end
  end

  // A drain without a new acceptance only clears valid; data stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_id     <= 1'b0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
      rsp_id     <= acc1;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: expected results are queued on acceptance
// and a monitor pops and compares them whenever a result is consumed.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req0_lock;
  logic [15:0] req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready, req1_lock;
  logic [15:0] req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_id, locked;
  logic [15:0] rsp_result;

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        id;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] r;
    logic        z;
  } vec_t;

  exp_t sb[$];
  exp_t exp0, exp1, popped;
  int   total = 0;
  int   bad   = 0;

  vec_t arith [7] = '{
    '{16'hFFFF, 16'h0001, ALU_ADD, 16'h0000, 1'b1},
    '{16'h0001, 16'hFFFF, ALU_SLT, 16'h0001, 1'b0},
    '{16'hFFFF, 16'h0001, ALU_SLT, 16'h0000, 1'b1},
    '{16'h0002, 16'h0003, 4'hF,    16'h0005, 1'b0},
    '{16'hF0F0, 16'hFF00, ALU_AND, 16'hF000, 1'b0},
    '{16'h00F0, 16'h0F00, ALU_OR,  16'h0FF0, 1'b0},
    '{16'h0003, 16'h0005, ALU_SUB, 16'hFFFE, 1'b0}
  };

  alu_arbiter #(.WIDTH(16), .OPW(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req0_lock  (req0_lock),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .req1_lock  (req1_lock),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_id     (rsp_id),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int port, input logic v,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] op, input logic lock,
                               input logic [15:0] er, input logic ez);
    if (port == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op; req0_lock = lock;
      exp0 = {er, ez, 1'b0};
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op; req1_lock = lock;
      exp1 = {er, ez, 1'b1};
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Pop before push so an older result is always compared first.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_unexpected_result", {16'h0, rsp_result}, 32'hDEAD);
        end else begin
          popped = sb.pop_front();
          checkOutput("sb_result", rsp_result, popped.result);
          checkOutput("sb_zero",   rsp_zero,   popped.zero);
          checkOutput("sb_id",     rsp_id,     popped.id);
        end
      end
      if (req0_valid && req0_ready) sb.push_back(exp0);
      if (req1_valid && req1_ready) sb.push_back(exp1);
    end
  end

  initial begin
    reset     = 1'b1;
    rsp_ready = 1'b1;
    applyStimulus(0, 1'b1, 16'h0, 16'h0, ALU_ADD, 1'b0, 16'h0, 1'b1);
    applyStimulus(1, 1'b0, 16'h0, 16'h0, ALU_ADD, 1'b0, 16'h0, 1'b1);

    @(negedge clk);
    checkOutput("reset_rsp_valid",  rsp_valid,  0);
    checkOutput("reset_rsp_result", rsp_result, 0);
    checkOutput("reset_rsp_zero",   rsp_zero,   0);
    checkOutput("reset_rsp_id",     rsp_id,     0);
    checkOutput("reset_locked",     locked,     0);
    checkOutput("reset_req0_ready", req0_ready, 0);
    nextCycle();
    reset = 1'b0;

    // single request, one-cycle latency
    applyStimulus(0, 1'b1, 16'h0005, 16'h0003, ALU_ADD, 1'b0, 16'h0008, 1'b0);
    @(negedge clk);
    checkOutput("single_req0_ready", req0_ready, 1);
    checkOutput("single_req1_ready", req1_ready, 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("single_rsp_valid",  rsp_valid,  1);
    checkOutput("single_rsp_result", rsp_result, 16'h0008);
    checkOutput("single_rsp_zero",   rsp_zero,   0);
    checkOutput("single_rsp_id",     rsp_id,     0);
    nextCycle();
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;

    // tie: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1'b1, 16'h0011, 16'h0022, ALU_ADD, 1'b0, 16'h0033, 1'b0);
      applyStimulus(1, 1'b1, 16'h0004, 16'h0004, ALU_SUB, 1'b0, 16'h0000, 1'b1);
      @(negedge clk);
      checkOutput("rr_req0_ready", req0_ready, (i % 2 == 0));
      checkOutput("rr_req1_ready", req1_ready, (i % 2 == 1));
      nextCycle();
    end

    // backpressure: result held five cycles, then drain + accept together
    applyStimulus(0, 1'b1, 16'h0010, 16'h0020, ALU_OR,  1'b0, 16'h0030, 1'b0);
    applyStimulus(1, 1'b1, 16'h0009, 16'h0003, ALU_SUB, 1'b0, 16'h0006, 1'b0);
    @(negedge clk);
    checkOutput("bp_first_req0_ready", req0_ready, 1);
    nextCycle();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_hold_valid",  rsp_valid,  1);
      checkOutput("bp_hold_result", rsp_result, 16'h0030);
      checkOutput("bp_hold_req0",   req0_ready, 0);
      checkOutput("bp_hold_req1",   req1_ready, 0);
      nextCycle();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_drain_valid", rsp_valid,  1);
    checkOutput("bp_drain_req1",  req1_ready, 1);
    checkOutput("bp_drain_req0",  req0_ready, 0);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("bp_next_result", rsp_result, 16'h0006);
    checkOutput("bp_next_id",     rsp_id,     1);
    nextCycle();

    // lock: req1 holds the ALU for three ops while req0 waits
    applyStimulus(0, 1'b1, 16'h0007, 16'h0001, ALU_ADD, 1'b0, 16'h0008, 1'b0);
    @(negedge clk);
    checkOutput("lock_pre_req0", req0_ready, 1);
    nextCycle();
    applyStimulus(1, 1'b1, 16'hFF0F, 16'h0FF0, ALU_AND, 1'b1, 16'h0F00, 1'b0);
    @(negedge clk);
    checkOutput("lock1_req1",   req1_ready, 1);
    checkOutput("lock1_req0",   req0_ready, 0);
    checkOutput("lock1_locked", locked,     0);
    nextCycle();
    applyStimulus(1, 1'b1, 16'h1234, 16'h1111, ALU_ADD, 1'b1, 16'h2345, 1'b0);
    @(negedge clk);
    checkOutput("lock2_req1",   req1_ready, 1);
    checkOutput("lock2_req0",   req0_ready, 0);
    checkOutput("lock2_locked", locked,     1);
    nextCycle();
    applyStimulus(1, 1'b1, 16'h0010, 16'h0001, ALU_SUB, 1'b0, 16'h000F, 1'b0);
    @(negedge clk);
    checkOutput("lock3_req1",   req1_ready, 1);
    checkOutput("lock3_req0",   req0_ready, 0);
    checkOutput("lock3_locked", locked,     1);
    nextCycle();
    req1_valid = 1'b0;
    @(negedge clk);
    checkOutput("unlock_locked", locked,     0);
    checkOutput("unlock_req0",   req0_ready, 1);
    nextCycle();
    idle();
    @(negedge clk);
    checkOutput("unlock_idle_locked", locked, 0);
    nextCycle();

    // arithmetic edge cases, back to back on requester 0
    for (int i = 0; i < 7; i++) begin
      applyStimulus(0, 1'b1, arith[i].a, arith[i].b, arith[i].op, 1'b0,
                    arith[i].r, arith[i].z);
      @(negedge clk);
      checkOutput("arith_req0_ready", req0_ready, 1);
      nextCycle();
    end
    idle();
    nextCycle();

    // async reset while locked with a held result
    rsp_ready = 1'b0;
    applyStimulus(1, 1'b1, 16'h0100, 16'h0001, ALU_ADD, 1'b1, 16'h0101, 1'b0);
    @(negedge clk);
    checkOutput("rst_lock_req1", req1_ready, 1);
    nextCycle();
    req1_valid = 1'b0;
    applyStimulus(0, 1'b1, 16'h0001, 16'h0001, ALU_ADD, 1'b0, 16'h0002, 1'b0);
    @(negedge clk);
    checkOutput("rst_pre_locked", locked,     1);
    checkOutput("rst_pre_valid",  rsp_valid,  1);
    checkOutput("rst_pre_result", rsp_result, 16'h0101);
    checkOutput("rst_owner_idle_req0", req0_ready, 0);
    nextCycle();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("rst_async_valid",  rsp_valid,  0);
    checkOutput("rst_async_locked", locked,     0);
    checkOutput("rst_async_result", rsp_result, 0);
    checkOutput("rst_async_req0",   req0_ready, 0);
    @(negedge clk);
    nextCycle();
    reset     = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(0, 1'b1, 16'h0001, 16'h0002, ALU_ADD, 1'b0, 16'h0003, 1'b0);
    applyStimulus(1, 1'b1, 16'h0004, 16'h0005, ALU_ADD, 1'b0, 16'h0009, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_req0", req0_ready, 1);
    checkOutput("post_rst_req1", req1_ready, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("post_rst2_req1", req1_ready, 1);
    checkOutput("post_rst2_req0", req0_ready, 0);
    nextCycle();
    idle();
    repeat (3) nextCycle();
    checkOutput("sb_empty_at_end", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
